// File: rtl/cmp_result_debounce_if.sv
// Bundle between a magnitude-comparator front end and the result debouncer:
// raw flags in, qualified compare state and bookkeeping pulses out.
interface cmp_result_debounce_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 sample_valid;
  logic                 greater;
  logic                 equal;
  logic                 smaller;
  logic                 clear_count;
  logic [1:0]           state;
  logic                 state_changed;
  logic                 illegal;
  logic [CNT_WIDTH-1:0] trans_count;

  // Producer side: drives comparator flags and the count clear.
  modport master (
    output sample_valid,
    output greater,
    output equal,
    output smaller,
    output clear_count,
    input  state,
    input  state_changed,
    input  illegal,
    input  trans_count
  );

  // Debouncer side.
  modport slave (
    input  sample_valid,
    input  greater,
    input  equal,
    input  smaller,
    input  clear_count,
    output state,
    output state_changed,
    output illegal,
    output trans_count
  );
endinterface

// File: rtl/cmp_result_debounce.sv
// Debounces comparator greater/equal/smaller flags: a compare result becomes the
// qualified state only after STABLE_COUNT consecutive identical valid samples.
module cmp_result_debounce #(
  parameter int STABLE_COUNT = 4,
  parameter int SC_WIDTH     = 4,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  cmp_result_debounce_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_UNKNOWN = 2'b00,
    ST_SMALLER = 2'b01,
    ST_EQUAL   = 2'b10,
    ST_GREATER = 2'b11
  } cmp_state_e;

  localparam logic [SC_WIDTH-1:0] SC_MAX = SC_WIDTH'(STABLE_COUNT);

  cmp_state_e           state_q,   state_d;
  cmp_state_e           cand_q,    cand_d;
  logic [SC_WIDTH-1:0]  stab_q,    stab_d;
  logic [CNT_WIDTH-1:0] count_q,   count_d;
  logic                 changed_q, changed_d;
  logic                 illegal_q, illegal_d;

  cmp_state_e           sample_class;
  logic                 sample_legal;

  // Anything other than a clean one-hot flag set (including 000) is illegal.
  always_comb begin
    sample_class = ST_UNKNOWN;
    sample_legal = 1'b0;
    case ({bus.greater, bus.equal, bus.smaller})
      3'b100: begin sample_class = ST_GREATER; sample_legal = 1'b1; end
      3'b010: begin sample_class = ST_EQUAL;   sample_legal = 1'b1; end
      3'b001: begin sample_class = ST_SMALLER; sample_legal = 1'b1; end
      default: begin sample_class = ST_UNKNOWN; sample_legal = 1'b0; end
    endcase
  end

  // Candidate tracking, qualification and transition counting.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    stab_d    = stab_q;
    count_d   = count_q;
    changed_d = 1'b0;
    illegal_d = 1'b0;

    if (bus.sample_valid) begin
      if (!sample_legal) begin
        illegal_d = 1'b1;
        cand_d    = ST_UNKNOWN;
        stab_d    = '0;
      end else begin
        if (sample_class == cand_q) begin
          stab_d = (stab_q >= SC_MAX) ? SC_MAX : stab_q + SC_WIDTH'(1);
        end else begin
          cand_d = sample_class;
          stab_d = SC_WIDTH'(1);
        end

        // Re-qualifying the current state is silent; only a real change counts.
        if (stab_d == SC_MAX && cand_d != state_q) begin
          state_d   = cand_d;
          changed_d = 1'b1;
          if (count_q != '1) begin
            count_d = count_q + CNT_WIDTH'(1);
          end
        end
      end
    end

    if (bus.clear_count) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_UNKNOWN;
      cand_q    <= ST_UNKNOWN;
      stab_q    <= '0;
      count_q   <= '0;
      changed_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      stab_q    <= stab_d;
      count_q   <= count_d;
      changed_q <= changed_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.state         = state_q;
  assign bus.state_changed = changed_q;
  assign bus.illegal       = illegal_q;
  assign bus.trans_count   = count_q;

endmodule

// File: doc/cmp_result_debounce.md
Name: cmp_result_debounce

Overview:
- Downstream consumer of the n-bit magnitude comparator (greater/equal/smaller flags).
- Samples the three flags on a valid strobe and qualifies a new compare state only after it has held for STABLE_COUNT consecutive samples.
- Flags illegal flag encodings and counts qualified state changes.
- Feeds control logic that must not react to single-sample comparator glitches or noisy operands.

Parameters:
STABLE_COUNT  4  consecutive identical valid samples required to qualify a state; legal range 1..2^SC_WIDTH-1
SC_WIDTH      4  width of the internal stability counter
CNT_WIDTH     8  width of the transition counter

Ports:
clk            input   1          system clock, rising edge
reset          input   1          asynchronous, active-high reset
sample_valid   input   1          greater/equal/smaller valid this cycle
greater        input   1          comparator a>b flag
equal          input   1          comparator a==b flag
smaller        input   1          comparator a<b flag
clear_count    input   1          synchronous clear of trans_count
state          output  2          qualified state: 00 UNKNOWN, 01 SMALLER, 10 EQUAL, 11 GREATER
state_changed  output  1          one-cycle pulse when state updates
illegal        output  1          one-cycle pulse on a valid sample that is not exactly one-hot
trans_count    output  CNT_WIDTH  number of qualified state changes, saturating

Behaviour:
- Reset (async, immediate): state=UNKNOWN, state_changed=0, illegal=0, trans_count=0, candidate=UNKNOWN, stab_cnt=0. All outputs registered.
- Class decode: {greater,equal,smaller} = 100 -> GREATER, 010 -> EQUAL, 001 -> SMALLER; any other value, including 000 and X, is illegal.
- sample_valid=0: candidate, stab_cnt and state hold; state_changed=0; illegal=0.
- Valid legal sample, class==candidate: stab_cnt_next = min(stab_cnt+1, STABLE_COUNT), saturating.
- Valid legal sample, class!=candidate: candidate_next = class; stab_cnt_next = 1.
- Qualification: if stab_cnt_next==STABLE_COUNT and candidate_next!=state:
  - state <= candidate_next at the same edge; new state visible the cycle after the qualifying sample (latency 1 clk from the STABLE_COUNT-th sample).
  - state_changed <= 1 for exactly one cycle.
  - trans_count increments unless already at all-ones, where it saturates.
- Re-qualifying the current state (candidate_next==state) produces no pulse and no count.
- Valid illegal sample: illegal <= 1 for one cycle; candidate <= UNKNOWN; stab_cnt <= 0; state holds; no state_changed.
- STABLE_COUNT=1: state follows every legal valid sample that differs from state, with 1-clk latency.
- UNKNOWN is never re-entered after reset; only reset returns state to UNKNOWN.
- clear_count=1: trans_count <= 0 at the next edge. Clear has priority over a simultaneous increment; state_changed still pulses.
- Reset asserted mid-qualification: all progress is discarded immediately. After release, the first valid sample restarts at stab_cnt=1.
- Internal FSM: qualified state register {UNKNOWN, SMALLER, EQUAL, GREATER} plus candidate register and stab_cnt. There are no other states.

Test Plan:
- Reset, then three valid samples of 100 at STABLE_COUNT=3 -> state=11 one cycle after the 3rd sample; state_changed pulses once; trans_count=1.
- STABLE_COUNT=3, samples 100,100,010,100,100,100 -> state unchanged until after the 6th sample, then 11; no pulse before that.
- From state GREATER, sample 110 -> illegal=1 for one cycle; state stays 11; next two 010 samples do not qualify; third 010 sample -> state=10, trans_count=2.
- sample_valid toggled low between identical 001 samples (001, gap, 001, gap, 001) -> gaps ignored; qualifies SMALLER after the 3rd valid sample.
- CNT_WIDTH=2, drive 5 alternating qualified transitions -> trans_count saturates at 3. Assert clear_count on the cycle of a 6th transition -> trans_count=0 and state_changed=1.
- Assert reset asynchronously, mid-edge, after 2 of 3 qualifying samples -> outputs reset immediately. After release, 1 more sample does not qualify; 3 samples are required.
